axi_write_buffer: RTL and testbench
===================================

Name: axi_write_buffer

Overview:
- Parametrised posted-write buffer between the uncached/store path of the data bus and the AXI write channels.
- Accepts CPU stores in one cycle and drains them in order as single-beat AXI writes, with one write outstanding at a time.
- Can merge a store into the youngest not-yet-issued entry for the same word.
- Reports address hits so the read path can stall on read-after-write to a buffered word.

Parameters:
- DEPTH, 8, number of entries; power of two, at least 2.
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, data width; must be 32 or 64; strobe width is DATA_WIDTH/8.
- MERGE_EN, 1, 1 enables merging a store into the tail entry.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- push_valid  in  1  store request
- push_ready  out  1  store accepted this cycle when push_valid is high
- push_addr  in  ADDR_WIDTH  store byte address
- push_data  in  DATA_WIDTH  store data, byte lanes aligned
- push_strb  in  DATA_WIDTH/8  byte enables
- query_addr  in  ADDR_WIDTH  read address to check
- query_hit  out  1  a valid entry, including the one in flight, matches query_addr at word granularity
- empty  out  1  no entries and no write in flight
- count  out  $clog2(DEPTH+1)  number of occupied entries
- bus_err  out  1  one-cycle pulse when bresp is not OKAY
- awaddr  out  ADDR_WIDTH; awlen  out  4; awsize  out  3; awburst  out  2
- awvalid  out  1; awready  in  1
- wdata  out  DATA_WIDTH; wstrb  out  DATA_WIDTH/8; wlast  out  1
- wvalid  out  1; wready  in  1
- bresp  in  2; bvalid  in  1; bready  out  1

Behaviour:
- Reset values: all entries invalid, count=0, empty=1, state=IDLE, awvalid=wvalid=bready=0, bus_err=0, query_hit=0. push_ready is 1 after reset.
- Word address: addr with the low log2(DATA_WIDTH/8) bits cleared. awaddr always carries the word address.
- Constant AXI fields: awlen=0, awsize=log2(DATA_WIDTH/8), awburst=2'b01, wlast=1.
- Storage: circular FIFO with head/tail pointers of log2(DEPTH) bits that wrap modulo DEPTH. count distinguishes full (count=DEPTH) from empty.
- Merge condition, all must hold:
  - MERGE_EN=1 and count>0.
  - The tail entry's word address equals push_addr's word address.
  - The tail entry is not the in-flight head (state==IDLE or count>1).
- On merge:
  - For each byte i with push_strb[i]=1, data byte i is overwritten.
  - The entry's strobe becomes old strb OR push_strb.
  - count is unchanged; merge is legal even when full.
- push_ready is 1 when the merge condition holds, or when count<DEPTH. There is no same-cycle pop-to-push bypass when full.
- Non-merge push: write at tail, tail+1, count+1.
- Simultaneous push and pop: count stays unchanged.
- FSM:
  - IDLE: if count>0, load head into the output registers and go to REQ, with awvalid=wvalid=1 on the next cycle.
  - REQ: awvalid drops after the awvalid&awready handshake; wvalid drops after the wvalid&wready handshake. The two handshakes are tracked independently (aw_done, w_done) and may occur in either order or in the same cycle. When both are done, go to RESP with bready=1.
  - RESP: on bvalid, pop head (head+1, count-1) and go to IDLE. If bresp is not 2'b00, pulse bus_err for one cycle. The entry is dropped regardless; there is no retry.
- Minimum throughput: 1 write per 3 cycles (IDLE, REQ, RESP), assuming zero-wait slave.
- AXI payload is held stable while its valid is high, and is never changed mid-handshake.
- query_hit is combinational over all valid entries; the in-flight head stays counted until popped.
- empty = (count==0) && state==IDLE.
- Asserting rst mid-transaction drops all valids immediately and discards buffered data. Software must not rely on buffered stores across reset.

Test Plan:
- Push addr 0x1000 data 0x11223344 strb 4'hF, zero-wait slave -> one AW/W with awaddr=0x1000, awsize=2, wstrb=4'hF; bready high; count returns 0; empty=1 after pop.
- Push 0x2000 strb 4'h1 data 0x000000AA, then 0x2002 strb 4'h4 data 0x00BB0000 while the AXI slave holds awready=0 -> single write, wdata=0x00BB00AA, wstrb=4'h5, count peaks at 1.
- DEPTH=8, slave stalled: push 8 distinct words -> push_ready=0 at count=8. Then push the same word as the tail -> push_ready=1 and merged. Release the slave -> 8 writes in push order; pointers wrap.
- wready asserted 3 cycles before awready -> wvalid drops after its handshake, awvalid held; exactly one B accepted and one pop.
- bresp=2'b10 on the first of two queued writes -> bus_err high for exactly 1 cycle; the second write still issues.
- query_addr=0x1004 while 0x1004 is in RESP -> query_hit=1 until the cycle after the bvalid pop, then 0. Assert rst in REQ -> awvalid=wvalid=0 immediately, count=0.

Source files
------------

// File: rtl/axi_write_buffer.sv
// axi_write_buffer: posted-write buffer between the uncached store path and
// the AXI write channels. Stores are accepted in one cycle, optionally merged
// into the youngest not-yet-issued entry for the same word, and drained in
// order as single-beat AXI writes with at most one write outstanding.
module axi_write_buffer #(
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MERGE_EN   = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_valid,
    output logic                         push_ready,
    input  logic [ADDR_WIDTH-1:0]        push_addr,
    input  logic [DATA_WIDTH-1:0]        push_data,
    input  logic [DATA_WIDTH/8-1:0]      push_strb,
    input  logic [ADDR_WIDTH-1:0]        query_addr,
    output logic                         query_hit,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         bus_err,
    output logic [ADDR_WIDTH-1:0]        awaddr,
    output logic [3:0]                   awlen,
    output logic [2:0]                   awsize,
    output logic [1:0]                   awburst,
    output logic                         awvalid,
    input  logic                         awready,
    output logic [DATA_WIDTH-1:0]        wdata,
    output logic [DATA_WIDTH/8-1:0]      wstrb,
    output logic                         wlast,
    output logic                         wvalid,
    input  logic                         wready,
    input  logic [1:0]                   bresp,
    input  logic                         bvalid,
    output logic                         bready
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(STRB_W - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_t;

    // Entry storage; addresses are kept as word addresses
    logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem [DEPTH];
    logic [STRB_W-1:0]     strb_mem [DEPTH];

    logic [DEPTH-1:0]      valid_reg;
    logic [PTR_W-1:0]      head_reg;
    logic [PTR_W-1:0]      tail_reg;
    logic [PTR_W-1:0]      tail_last;
    logic [CNT_W-1:0]      count_reg;

    state_t                state_reg;
    logic                  aw_done_reg;
    logic                  w_done_reg;
    logic                  awvalid_reg;
    logic                  wvalid_reg;
    logic                  bready_reg;
    logic                  bus_err_reg;
    logic [ADDR_WIDTH-1:0] awaddr_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;
    logic [STRB_W-1:0]     wstrb_reg;

    logic [ADDR_WIDTH-1:0] push_word;
    logic [ADDR_WIDTH-1:0] query_word;
    logic                  merge_ok;
    logic                  push_fire;
    logic                  push_new;
    logic                  merge_fire;
    logic                  load_fwd;
    logic                  pop;
    logic                  aw_hs;
    logic                  w_hs;
    logic [DATA_WIDTH-1:0] merged_data;
    logic [STRB_W-1:0]     merged_strb;
    logic [DEPTH-1:0]      hit_vec;

    assign push_word  = push_addr & WORD_MASK;
    assign query_word = query_addr & WORD_MASK;
    assign tail_last  = tail_reg - PTR_W'(1);

    // The youngest entry may absorb a store unless it is already on the bus
    assign merge_ok = (MERGE_EN != 0) && (count_reg != '0) &&
                      (addr_mem[tail_last] == push_word) &&
                      ((state_reg == IDLE) || (count_reg > CNT_W'(1)));

    assign push_ready = merge_ok || (count_reg < CNT_W'(DEPTH));
    assign push_fire  = push_valid && push_ready;
    assign merge_fire = push_fire && merge_ok;
    assign push_new   = push_fire && !merge_ok;

    // A merge into the head in the same cycle it is loaded must be forwarded,
    // otherwise the merged bytes would miss the outgoing beat
    assign load_fwd = merge_fire && (tail_last == head_reg);

    assign aw_hs = awvalid_reg && awready;
    assign w_hs  = wvalid_reg && wready;
    assign pop   = (state_reg == RESP) && bvalid;

    genvar gi;
    generate
        for (gi = 0; gi < STRB_W; gi++) begin : g_merge
            assign merged_data[gi*8 +: 8] = push_strb[gi] ? push_data[gi*8 +: 8]
                                                          : data_mem[tail_last][gi*8 +: 8];
        end
        for (gi = 0; gi < DEPTH; gi++) begin : g_hit
            assign hit_vec[gi] = valid_reg[gi] && (addr_mem[gi] == query_word);
        end
    endgenerate

    assign merged_strb = strb_mem[tail_last] | push_strb;
    assign query_hit   = |hit_vec;
    assign empty       = (count_reg == '0) && (state_reg == IDLE);
    assign count       = count_reg;

    assign awaddr  = awaddr_reg;
    assign awlen   = 4'd0;
    assign awsize  = 3'($clog2(STRB_W));
    assign awburst = 2'b01;
    assign awvalid = awvalid_reg;
    assign wdata   = wdata_reg;
    assign wstrb   = wstrb_reg;
    assign wlast   = 1'b1;
    assign wvalid  = wvalid_reg;
    assign bready  = bready_reg;
    assign bus_err = bus_err_reg;

    // Entry payload: new stores land at the tail, merges rewrite the youngest entry
    always_ff @(posedge clk) begin
        if (push_new) begin
            addr_mem[tail_reg] <= push_word;
            data_mem[tail_reg] <= push_data;
            strb_mem[tail_reg] <= push_strb;
        end else if (merge_fire) begin
            data_mem[tail_last] <= merged_data;
            strb_mem[tail_last] <= merged_strb;
        end
    end

    // Occupancy bookkeeping: valid bits, wrapping pointers and count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg <= '0;
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (push_new) begin
                valid_reg[tail_reg] <= 1'b1;
                tail_reg            <= tail_reg + PTR_W'(1);
            end
            if (pop) begin
                valid_reg[head_reg] <= 1'b0;
                head_reg            <= head_reg + PTR_W'(1);
            end
            count_reg <= count_reg + CNT_W'(push_new) - CNT_W'(pop);
        end
    end

    // Drain FSM: load head, run independent AW/W handshakes, then wait for B
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
            awvalid_reg <= 1'b0;
            wvalid_reg  <= 1'b0;
            bready_reg  <= 1'b0;
            bus_err_reg <= 1'b0;
            awaddr_reg  <= '0;
            wdata_reg   <= '0;
            wstrb_reg   <= '0;
        end else begin
            bus_err_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (count_reg != '0) begin
                        awaddr_reg  <= addr_mem[head_reg];
                        wdata_reg   <= load_fwd ? merged_data : data_mem[head_reg];
                        wstrb_reg   <= load_fwd ? merged_strb : strb_mem[head_reg];
                        awvalid_reg <= 1'b1;
                        wvalid_reg  <= 1'b1;
                        aw_done_reg <= 1'b0;
                        w_done_reg  <= 1'b0;
                        state_reg   <= REQ;
                    end
                end
                REQ: begin
                    if (aw_hs) begin
                        awvalid_reg <= 1'b0;
                        aw_done_reg <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid_reg <= 1'b0;
                        w_done_reg <= 1'b1;
                    end
                    if ((aw_done_reg || aw_hs) && (w_done_reg || w_hs)) begin
                        bready_reg <= 1'b1;
                        state_reg  <= RESP;
                    end
                end
                RESP: begin
                    if (bvalid) begin
                        bready_reg <= 1'b0;
                        state_reg  <= IDLE;
                        if (bresp != 2'b00) begin
                            bus_err_reg <= 1'b1;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_write_buffer.sv
// Directed testbench for axi_write_buffer: a scripted store sequence with a
// scoreboard of expected AXI beats and a small controllable AXI slave.
module tb_axi_write_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        push_valid;
    logic        push_ready;
    logic [31:0] push_addr;
    logic [31:0] push_data;
    logic [3:0]  push_strb;
    logic [31:0] query_addr;
    logic        query_hit;
    logic        empty;
    logic [3:0]  count;
    logic        bus_err;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    always #5 clk = ~clk;

    axi_write_buffer #(
        .DEPTH(8), .ADDR_WIDTH(32), .DATA_WIDTH(32), .MERGE_EN(1)
    ) dut (
        .clk(clk), .rst(rst),
        .push_valid(push_valid), .push_ready(push_ready),
        .push_addr(push_addr), .push_data(push_data), .push_strb(push_strb),
        .query_addr(query_addr), .query_hit(query_hit),
        .empty(empty), .count(count), .bus_err(bus_err),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
    } wbeat_t;

    logic [31:0] exp_aw_q [$];
    wbeat_t      exp_w_q  [$];

    int n_compared   = 0;
    int n_mismatched = 0;

    // Slave controls and observed-event counters
    logic aw_hold = 1'b0;
    logic w_hold  = 1'b0;
    logic b_hold  = 1'b0;
    int   err_at  = -1;
    int   aw_hs_cnt = 0;
    int   w_hs_cnt  = 0;
    int   b_hs_cnt  = 0;
    int   bus_err_cycles = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // AXI slave and beat monitor: drives ready/B a little after each falling
    // edge, then scores the handshakes that the next rising edge will take
    initial begin
        wbeat_t e;
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        bresp   = 2'b00;
        forever begin
            @(negedge clk);
            #1;
            awready = !aw_hold;
            wready  = !w_hold;
            bvalid  = bready && !b_hold;
            bresp   = (b_hs_cnt == err_at) ? 2'b10 : 2'b00;
            if (bus_err) bus_err_cycles++;
            if (!rst && awvalid && awready) begin
                aw_hs_cnt++;
                check("aw_expected", 64'(exp_aw_q.size() != 0), 64'(1));
                if (exp_aw_q.size() != 0) begin
                    check("awaddr", 64'(awaddr), 64'(exp_aw_q.pop_front()));
                    $display("AW  addr=0x%08h len=%0d size=%0d burst=%0d", awaddr, awlen, awsize, awburst);
                end
                check("awlen", 64'(awlen), 64'(0));
                check("awsize", 64'(awsize), 64'(2));
                check("awburst", 64'(awburst), 64'(1));
            end
            if (!rst && wvalid && wready) begin
                w_hs_cnt++;
                check("w_expected", 64'(exp_w_q.size() != 0), 64'(1));
                if (exp_w_q.size() != 0) begin
                    e = exp_w_q.pop_front();
                    check("wdata", 64'(wdata), 64'(e.data));
                    check("wstrb", 64'(wstrb), 64'(e.strb));
                    $display("W   data=0x%08h strb=0x%h last=%0b", wdata, wstrb, wlast);
                end
                check("wlast", 64'(wlast), 64'(1));
            end
            if (!rst && bvalid && bready) begin
                b_hs_cnt++;
                $display("B   resp=%0d", bresp);
            end
        end
    end

    // Drive one store for a cycle; record its expected beat in the scoreboard
    task automatic try_push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic exp_ready, input logic exp_merge, input string tag);
        wbeat_t e;
        push_valid = 1'b1;
        push_addr  = a;
        push_data  = d;
        push_strb  = s;
        #1;
        check({tag, "_ready"}, 64'(push_ready), 64'(exp_ready));
        $display("PUSH %s addr=0x%08h data=0x%08h strb=0x%h ready=%0b", tag, a, d, s, push_ready);
        if (exp_ready) begin
            if (exp_merge && exp_w_q.size() != 0) begin
                e = exp_w_q[exp_w_q.size() - 1];
                for (int k = 0; k < 4; k++) begin
                    if (s[k]) e.data[k*8 +: 8] = d[k*8 +: 8];
                end
                e.strb = e.strb | s;
                exp_w_q[exp_w_q.size() - 1] = e;
            end else begin
                exp_aw_q.push_back(a & 32'hFFFF_FFFC);
                e.data = d;
                e.strb = s;
                exp_w_q.push_back(e);
            end
        end
        @(negedge clk);
        push_valid = 1'b0;
    endtask

    task automatic wait_empty(input int budget, input string tag);
        int n = 0;
        while (!empty && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_drained"}, 64'(empty), 64'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        int w0;
        int b0;
        int e0;
        int n;
        push_valid = 1'b0;
        push_addr  = '0;
        push_data  = '0;
        push_strb  = '0;
        query_addr = '0;
        rst        = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_count", 64'(count), 64'(0));
        check("rst_empty", 64'(empty), 64'(1));
        check("rst_awvalid", 64'(awvalid), 64'(0));
        check("rst_wvalid", 64'(wvalid), 64'(0));
        check("rst_bready", 64'(bready), 64'(0));
        check("rst_bus_err", 64'(bus_err), 64'(0));
        check("rst_query_hit", 64'(query_hit), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        check("rst_push_ready", 64'(push_ready), 64'(1));

        // Single full-word store through a zero-wait slave
        b0 = b_hs_cnt;
        try_push(32'h1000, 32'h1122_3344, 4'hF, 1'b1, 1'b0, "t1_push");
        check("t1_count", 64'(count), 64'(1));
        check("t1_not_empty", 64'(empty), 64'(0));
        wait_empty(20, "t1");
        check("t1_count_end", 64'(count), 64'(0));
        check("t1_b_taken", 64'(b_hs_cnt - b0), 64'(1));

        // Two partial stores to one word merge while the slave stalls
        aw_hold = 1'b1;
        w_hold  = 1'b1;
        a0 = aw_hs_cnt;
        try_push(32'h2000, 32'h0000_00AA, 4'h1, 1'b1, 1'b0, "t2_push0");
        try_push(32'h2002, 32'h00BB_0000, 4'h4, 1'b1, 1'b1, "t2_merge");
        check("t2_count", 64'(count), 64'(1));
        repeat (3) @(negedge clk);
        check("t2_count_peak", 64'(count), 64'(1));
        check("t2_awvalid_held", 64'(awvalid), 64'(1));
        aw_hold = 1'b0;
        w_hold  = 1'b0;
        wait_empty(20, "t2");
        check("t2_single_write", 64'(aw_hs_cnt - a0), 64'(1));

        // Fill to DEPTH, refuse a new word, merge into the tail, then drain
        aw_hold = 1'b1;
        w_hold  = 1'b1;
        a0 = aw_hs_cnt;
        for (int i = 0; i < 8; i++) begin
            try_push(32'h3000 + 32'(4 * i), 32'hC0DE_0000 + 32'(i), 4'hF, 1'b1, 1'b0, "t3_fill");
        end
        check("t3_full_count", 64'(count), 64'(8));
        try_push(32'h4000, 32'h1234_5678, 4'hF, 1'b0, 1'b0, "t3_full");
        check("t3_full_count2", 64'(count), 64'(8));
        try_push(32'h301C, 32'h0000_EE00, 4'h2, 1'b1, 1'b1, "t3_merge_full");
        check("t3_after_merge", 64'(count), 64'(8));
        aw_hold = 1'b0;
        w_hold  = 1'b0;
        wait_empty(100, "t3");
        check("t3_writes", 64'(aw_hs_cnt - a0), 64'(8));

        // W handshake completes well before AW
        aw_hold = 1'b1;
        w_hold  = 1'b0;
        w0 = w_hs_cnt;
        b0 = b_hs_cnt;
        try_push(32'h5000, 32'hCAFE_F00D, 4'hF, 1'b1, 1'b0, "t4_push");
        n = 0;
        while (w_hs_cnt == w0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t4_w_hs", 64'(w_hs_cnt - w0), 64'(1));
        for (int i = 0; i < 3; i++) begin
            check("t4_wvalid_low", 64'(wvalid), 64'(0));
            check("t4_awvalid_held", 64'(awvalid), 64'(1));
            check("t4_bready_low", 64'(bready), 64'(0));
            @(negedge clk);
        end
        aw_hold = 1'b0;
        wait_empty(20, "t4");
        check("t4_one_b", 64'(b_hs_cnt - b0), 64'(1));
        check("t4_count", 64'(count), 64'(0));

        // Error response on the first of two queued writes
        aw_hold = 1'b1;
        w_hold  = 1'b1;
        a0 = aw_hs_cnt;
        b0 = b_hs_cnt;
        e0 = bus_err_cycles;
        try_push(32'h6000, 32'h600D_F00D, 4'hF, 1'b1, 1'b0, "t5_push0");
        try_push(32'h6010, 32'hBAD0_BEEF, 4'hF, 1'b1, 1'b0, "t5_push1");
        err_at  = b_hs_cnt;
        aw_hold = 1'b0;
        w_hold  = 1'b0;
        wait_empty(40, "t5");
        @(negedge clk);
        check("t5_bus_err_cycles", 64'(bus_err_cycles - e0), 64'(1));
        check("t5_writes", 64'(aw_hs_cnt - a0), 64'(2));
        check("t5_bs", 64'(b_hs_cnt - b0), 64'(2));
        err_at = -1;

        // Read-after-write hit held through RESP until the pop
        b_hold = 1'b1;
        query_addr = 32'h1004;
        @(negedge clk);
        check("t6_hit_before", 64'(query_hit), 64'(0));
        try_push(32'h1004, 32'h0BAD_CAFE, 4'hF, 1'b1, 1'b0, "t6_push");
        check("t6_hit_queued", 64'(query_hit), 64'(1));
        n = 0;
        while (!bready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t6_in_resp", 64'(bready), 64'(1));
        check("t6_hit_resp", 64'(query_hit), 64'(1));
        query_addr = 32'h1007;
        #1;
        check("t6_hit_same_word", 64'(query_hit), 64'(1));
        query_addr = 32'h1008;
        #1;
        check("t6_miss_next_word", 64'(query_hit), 64'(0));
        query_addr = 32'h1004;
        @(negedge clk);
        b_hold = 1'b0;
        check("t6_hit_before_pop", 64'(query_hit), 64'(1));
        @(negedge clk);
        check("t6_hit_after_pop", 64'(query_hit), 64'(0));
        check("t6_count", 64'(count), 64'(0));

        // Reset asserted while a write is in REQ
        aw_hold = 1'b1;
        w_hold  = 1'b1;
        query_addr = 32'h7000;
        try_push(32'h7000, 32'h7777_7777, 4'hF, 1'b1, 1'b0, "t7_push");
        n = 0;
        while (!awvalid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("t7_in_req", 64'(awvalid), 64'(1));
        check("t7_hit_req", 64'(query_hit), 64'(1));
        #2 rst = 1'b1;
        #1;
        check("t7_awvalid_rst", 64'(awvalid), 64'(0));
        check("t7_wvalid_rst", 64'(wvalid), 64'(0));
        check("t7_count_rst", 64'(count), 64'(0));
        check("t7_empty_rst", 64'(empty), 64'(1));
        check("t7_hit_rst", 64'(query_hit), 64'(0));
        exp_aw_q.delete();
        exp_w_q.delete();
        @(negedge clk);
        rst = 1'b0;
        a0 = aw_hs_cnt;
        aw_hold = 1'b0;
        w_hold  = 1'b0;
        repeat (5) @(negedge clk);
        check("t7_no_write", 64'(aw_hs_cnt - a0), 64'(0));
        check("t7_push_ready", 64'(push_ready), 64'(1));
        check("t7_empty_after", 64'(empty), 64'(1));

        // Every expected beat must have appeared on the bus
        check("end_aw_queue", 64'(exp_aw_q.size()), 64'(0));
        check("end_w_queue", 64'(exp_w_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
